sevenseg_scan_ctrl: RTL and testbench



---
 rtl/sevenseg_scan_ctrl.sv | 127 ++++++++++++
 tb/tb_sevenseg_scan_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit common-anode seven-segment
// display. A 16-bit hex value is captured into a shadow register and its
// digits are shown one per slot. Each slot opens with a blanking window
// (all anodes off) to suppress ghosting between digits.
module sevenseg_scan_ctrl #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic        load,
    input  logic [3:0]  digit_en,
    input  logic        lz_blank,
    output logic [6:0]  segments,
    output logic [3:0]  Anode_Activate,
    output logic        frame_tick
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

    logic [15:0]   shadow;
    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [3:0]    nib;
    logic          on;

    logic [15:0]   shadow_next;
    logic [1:0]    idx_next;
    logic          slot_end;
    logic          blank_phase;

    // Active-low abc_defg glyph for a hex nibble.
    function automatic logic [6:0] font(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b000_0001;
            4'h1: s = 7'b100_1111;
            4'h2: s = 7'b001_0010;
            4'h3: s = 7'b000_0110;
            4'h4: s = 7'b100_1100;
            4'h5: s = 7'b010_0100;
            4'h6: s = 7'b010_0000;
            4'h7: s = 7'b000_1111;
            4'h8: s = 7'b000_0000;
            4'h9: s = 7'b000_1100;
            4'hA: s = 7'b000_1000;
            4'hB: s = 7'b110_0000;
            4'hC: s = 7'b011_0001;
            4'hD: s = 7'b100_0010;
            4'hE: s = 7'b011_0000;
            default: s = 7'b011_1000;
        endcase
        return s;
    endfunction

    // Select hex digit k of a 16-bit word.
    function automatic logic [3:0] digit_of(input logic [15:0] w, input logic [1:0] k);
        logic [3:0] d;
        case (k)
            2'd0:    d = w[3:0];
            2'd1:    d = w[7:4];
            2'd2:    d = w[11:8];
            default: d = w[15:12];
        endcase
        return d;
    endfunction

    // A digit is a leading zero when it and every digit above it are zero;
    // the rightmost digit always stays visible so a zero value still shows "0".
    function automatic logic leading_zero(input logic [15:0] w, input logic [1:0] k);
        logic z;
        case (k)
            2'd0:    z = 1'b0;
            2'd1:    z = (w[15:4] == 12'h000);
            2'd2:    z = (w[15:8] == 8'h00);
            default: z = (w[15:12] == 4'h0);
        endcase
        return z;
    endfunction

    // Next-slot selection: a load on the boundary edge is already visible here.
    always_comb begin
        shadow_next = load ? value : shadow;
        idx_next    = idx + 2'd1;
        slot_end    = (cnt == CNT_LAST);
    end

    // Slot/digit sequencing; the digit shown is latched only at slot boundaries
    // so a mid-slot load never tears the current digit.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow <= 16'h0000;
            cnt    <= '0;
            idx    <= 2'd0;
            nib    <= 4'h0;
            on     <= 1'b0;
        end else begin
            if (load) begin
                shadow <= value;
            end
            if (slot_end) begin
                cnt <= '0;
                idx <= idx_next;
                nib <= digit_of(shadow_next, idx_next);
                on  <= digit_en[idx_next] &
                       ~(lz_blank & leading_zero(shadow_next, idx_next));
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Output decode purely from registered state.
    always_comb begin
        blank_phase    = (32'(cnt) < 32'(BLANK_CYCLES));
        segments       = 7'b111_1111;
        Anode_Activate = 4'b1111;
        if (!blank_phase && on) begin
            segments       = font(nib);
            Anode_Activate = ~(4'b0001 << idx);
        end
        frame_tick = (idx == 2'd3) && slot_end;
    end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Testbench for sevenseg_scan_ctrl: directed scenarios plus randomized
// traffic, checked cycle by cycle against a time-based reference model.
module tb_sevenseg_scan_ctrl;

    localparam int RD = 4;
    localparam int BC = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] value;
    logic        load;
    logic [3:0]  digit_en;
    logic        lz_blank;
    logic [6:0]  segments;
    logic [3:0]  Anode_Activate;
    logic        frame_tick;

    int n_tests = 0;
    int n_fail  = 0;
    int n_ticks = 0;

    // Reference model: time since reset plus the digit record taken at the
    // last slot boundary.
    int          t_m;
    logic [15:0] sh_m;
    logic [3:0]  nib_m;
    logic        vis_m;

    logic [6:0] font_m [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    sevenseg_scan_ctrl #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
        .clk(clk),
        .reset(reset),
        .value(value),
        .load(load),
        .digit_en(digit_en),
        .lz_blank(lz_blank),
        .segments(segments),
        .Anode_Activate(Anode_Activate),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, t_m);
        end
    endtask

    // Advance the model across one clock edge using the inputs presented to it.
    task automatic model_edge();
        logic [15:0] sh_new;
        int d;
        if (reset) begin
            t_m = 0; sh_m = 16'h0; nib_m = 4'h0; vis_m = 1'b0;
        end else begin
            sh_new = load ? value : sh_m;
            if (t_m % RD == RD - 1) begin
                d     = ((t_m / RD) + 1) % 4;
                nib_m = 4'((sh_new >> (4 * d)) & 16'hF);
                vis_m = digit_en[d] && !(lz_blank && d > 0 && (sh_new >> (4 * d)) == 16'h0);
            end
            sh_m = sh_new;
            t_m++;
        end
    endtask

    task automatic check_outputs();
        int   d;
        logic lit;
        logic [3:0] an_e;
        logic [6:0] seg_e;
        d     = (t_m / RD) % 4;
        lit   = vis_m && (t_m % RD >= BC);
        an_e  = lit ? ~(4'b0001 << d) : 4'b1111;
        seg_e = lit ? font_m[nib_m] : 7'b1111111;
        chk("anode", 32'(Anode_Activate), 32'(an_e));
        chk("segments", 32'(segments), 32'(seg_e));
        chk("frame_tick", 32'(frame_tick), 32'(t_m % (4 * RD) == 4 * RD - 1));
        chk("one_hot_anode", 32'($countones(~Anode_Activate) <= 1), 32'd1);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        if (frame_tick) n_ticks++;
        check_outputs();
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_load(input logic [15:0] v);
        value = v; load = 1'b1;
        cycle();
        load = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; value = 16'h0; load = 1'b0; digit_en = 4'hF; lz_blank = 1'b0;
        t_m = 0; sh_m = 16'h0; nib_m = 4'h0; vis_m = 1'b0;
        cycles(2);
        chk("rst_anode", 32'(Anode_Activate), 32'hF);
        chk("rst_segments", 32'(segments), 32'h7F);
        chk("rst_tick", 32'(frame_tick), 32'd0);
        reset = 1'b0;

        // Scenario 1: 1234 loaded in the first cycle after release.
        do_load(16'h1234);
        cycles(4);
        chk("s1_digit1_anode", 32'(Anode_Activate), 32'b1101);
        chk("s1_digit1_seg", 32'(segments), 32'b0000110);
        n_ticks = 0;
        cycles(32);
        chk("s1_tick_count", 32'(n_ticks), 32'd2);

        // Scenario 2: leading-zero suppression.
        lz_blank = 1'b1;
        do_load(16'h0005);
        cycles(20);
        do_load(16'h0105);
        cycles(20);
        lz_blank = 1'b0;

        // Scenario 3: sparse digit enables.
        digit_en = 4'b1010;
        do_load(16'h8888);
        cycles(20);
        digit_en = 4'hF;

        // Scenarios 4/5: loads mid-slot and on the boundary edge.
        do_reset();
        do_load(16'h1234);
        while (!(t_m % RD == 1 && (t_m / RD) % 4 == 1)) cycle();
        cycle();
        do_load(16'hFFFF);
        cycles(8);
        while (!(t_m % RD == RD - 1 && (t_m / RD) % 4 == 0)) cycle();
        do_load(16'hABCD);
        cycles(8);

        // Scenario 6: reset mid-frame.
        while (!(t_m % RD == 2 && (t_m / RD) % 4 == 2)) cycle();
        do_reset();
        chk("s6_anode", 32'(Anode_Activate), 32'hF);
        chk("s6_segments", 32'(segments), 32'h7F);
        cycles(20);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            load  = ($urandom_range(0, 7) == 0);
            value = 16'($urandom);
            for (int k = 0; k < 4; k++)
                if ($urandom_range(0, 2) == 0) value[4*k +: 4] = 4'h0;
            if ($urandom_range(0, 15) == 0) digit_en = 4'($urandom);
            if ($urandom_range(0, 15) == 0) lz_blank = 1'($urandom);
            cycle();
        end
        reset = 1'b0; load = 1'b0;
        cycles(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
